// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a framed byte stream (count, payload, checksum),
// writes little-endian words to instruction memory and releases the core once the image verifies.
module imem_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned RELEASE_DLY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RELEASE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] CAP      = 32'(1) << ADDR_W;
    localparam logic [7:0]  DLY_LAST = 8'(RELEASE_DLY);

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [ADDR_W:0]   widx_inc;
    logic [23:0]       wbuf_q, wbuf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        dly_q, dly_d;
    logic              rstn_q, rstn_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;

    assign rx_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept   = rx_valid && rx_ready;
    // Word index is one bit wider than the address so a full-capacity image terminates cleanly.
    assign widx_inc = widx_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        sum_d   = sum_q;
        widx_d  = widx_q;
        wbuf_d  = wbuf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dly_d   = dly_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: state_d = S_HDR;

            S_HDR: begin
                if (accept) begin
                    case (lane_q)
                        2'd0: cnt_d[7:0]   = rx_data;
                        2'd1: cnt_d[15:8]  = rx_data;
                        2'd2: cnt_d[23:16] = rx_data;
                        default: begin
                            cnt_d[31:24] = rx_data;
                            state_d      = S_LEN;
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
            end

            S_LEN: begin
                lane_d = '0;
                widx_d = '0;
                sum_d  = '0;
                if (cnt_q > CAP) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (accept) begin
                    sum_d  = sum_q + rx_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: wbuf_d[7:0]   = rx_data;
                        2'd1: wbuf_d[15:8]  = rx_data;
                        2'd2: wbuf_d[23:16] = rx_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {rx_data, wbuf_q};
                            addr_d  = widx_q[ADDR_W-1:0];
                            widx_d  = widx_inc;
                            if (widx_inc == cnt_q[ADDR_W:0]) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end

            S_CSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        state_d = S_RELEASE;
                        dly_d   = '0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            S_RELEASE: begin
                if (dly_q == DLY_LAST) begin
                    state_d = S_DONE;
                    rstn_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    dly_d = dly_q + 8'd1;
                end
            end

            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d = S_HDR;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    rstn_d  = 1'b0;
                    sum_d   = '0;
                    widx_d  = '0;
                    lane_d  = '0;
                    cnt_d   = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            sum_q   <= '0;
            widx_q  <= '0;
            wbuf_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dly_q   <= '0;
            rstn_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            sum_q   <= sum_d;
            widx_q  <= widx_d;
            wbuf_q  <= wbuf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dly_q   <= dly_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_reset_n = rstn_q;
    assign load_done    = done_q;
    assign load_err     = err_q;

endmodule
